// File: rtl/gshare_ctrl.sv
// gshare front-end controller: forms the PHT read index from PC and speculative history,
// tracks predicted branches in flight, and issues PHT updates and history repair on resolve.
module gshare_ctrl #(
    parameter int INDEX_WIDTH = 6,
    parameter int DEPTH       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fetch_valid_i,
    input  logic [31:0]            fetch_pc_i,
    input  logic                   pht_pred_i,
    output logic [INDEX_WIDTH-1:0] pht_rd_index_o,
    output logic                   fetch_ready_o,
    input  logic                   resolve_valid_i,
    input  logic                   resolve_taken_i,
    input  logic                   flush_i,
    output logic                   update_en_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   br_taken_o,
    output logic                   mispredict_o,
    output logic [INDEX_WIDTH-1:0] ghr_spec_o
);

    localparam int PW = $clog2(DEPTH);

    logic [INDEX_WIDTH-1:0] r_ghr_spec;
    logic [INDEX_WIDTH-1:0] r_ghr_arch;
    logic [INDEX_WIDTH-1:0] r_q_idx  [DEPTH];
    logic                   r_q_pred [DEPTH];
    logic [PW:0]            r_wr_ptr;
    logic [PW:0]            r_rd_ptr;

    logic                   r_update_en;
    logic [INDEX_WIDTH-1:0] r_update_index;
    logic                   r_br_taken;
    logic                   r_mispredict;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_mispredict;
    logic [INDEX_WIDTH-1:0] w_rd_index;
    logic [INDEX_WIDTH-1:0] w_head_idx;
    logic                   w_head_pred;
    logic [INDEX_WIDTH-1:0] w_ghr_arch_next;
    logic [INDEX_WIDTH-1:0] w_ghr_spec_push;
    logic                   w_unused_pc;

    // Only the word-aligned index bits of the PC participate in the hash.
    assign w_unused_pc = ^{fetch_pc_i[31:INDEX_WIDTH+2], fetch_pc_i[1:0]};

    assign w_rd_index = fetch_pc_i[INDEX_WIDTH+1:2] ^ r_ghr_spec;

    assign w_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_head_idx  = r_q_idx[r_rd_ptr[PW-1:0]];
    assign w_head_pred = r_q_pred[r_rd_ptr[PW-1:0]];

    assign w_pop        = resolve_valid_i && !w_empty && !flush_i;
    assign w_mispredict = w_pop && (w_head_pred != resolve_taken_i);
    // Readiness ignores a same-cycle pop so that it never depends on resolve timing.
    assign w_push       = fetch_valid_i && !w_full && !flush_i && !w_mispredict;

    assign w_ghr_arch_next = {r_ghr_arch[INDEX_WIDTH-2:0], resolve_taken_i};
    assign w_ghr_spec_push = {r_ghr_spec[INDEX_WIDTH-2:0], pht_pred_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ghr_spec     <= '0;
            r_ghr_arch     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_update_en    <= 1'b0;
            r_update_index <= '0;
            r_br_taken     <= 1'b0;
            r_mispredict   <= 1'b0;
        end else begin
            r_update_en  <= w_pop;
            r_mispredict <= w_mispredict;
            if (w_pop) begin
                r_update_index <= w_head_idx;
                r_br_taken     <= resolve_taken_i;
                r_ghr_arch     <= w_ghr_arch_next;
            end
            if (flush_i) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_ghr_spec <= r_ghr_arch;
            end else if (w_mispredict) begin
                // Younger entries were predicted down the wrong path; restart from committed history.
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_ghr_spec <= w_ghr_arch_next;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_ghr_spec <= w_ghr_spec_push;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // Queue payload needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr[PW-1:0]]  <= w_rd_index;
            r_q_pred[r_wr_ptr[PW-1:0]] <= pht_pred_i;
        end
    end

    assign pht_rd_index_o = w_rd_index;
    assign fetch_ready_o  = !w_full;
    assign update_en_o    = r_update_en;
    assign update_index_o = r_update_index;
    assign br_taken_o     = r_br_taken;
    assign mispredict_o   = r_mispredict;
    assign ghr_spec_o     = r_ghr_spec;

endmodule
